// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result bundle between the controller and seq_alu.
//   start, opcode, in_ac, in_dr : request side (driven by the controller)
//   busy, done                  : status (driven by the ALU)
//   out_reg, carry, zero        : registered result and flags (driven by the ALU)
interface seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] in_ac;
    logic [WIDTH-1:0] in_dr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_reg;
    logic             carry;
    logic             zero;

    modport master (
        output start, opcode, in_ac, in_dr,
        input  busy, done, out_reg, carry, zero
    );

    modport slave (
        input  start, opcode, in_ac, in_dr,
        output busy, done, out_reg, carry, zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle ops and an iterative square root.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : seq_alu_if slave port (start/opcode/in_ac/in_dr in;
//          busy/done/out_reg/carry/zero out)
// WIDTH must be even and at least 4.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    typedef enum logic [0:0] {StIdle, StSqrt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   odd_q, odd_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;

    assign sum = {1'b0, bus.in_ac} + {1'b0, bus.in_dr};

    // Result of the single-cycle ops; opcode 111 is handled by the FSM.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (bus.opcode)
            3'b000: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            3'b001: begin
                res   = bus.in_ac - bus.in_dr;
                res_c = bus.in_ac < bus.in_dr;
            end
            3'b010:  res = (bus.in_ac == bus.in_dr) ? WIDTH'(1) : '0;
            3'b011: begin
                res   = {bus.in_dr[WIDTH-2:0], 1'b0};
                res_c = bus.in_dr[WIDTH-1];
            end
            3'b100:  res = bus.in_dr;
            3'b101:  res = bus.in_ac;
            3'b110:  res = ~bus.in_dr;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        odd_d   = odd_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.opcode == 3'b111) begin
                        rem_d   = bus.in_dr;
                        odd_d   = (WIDTH+1)'(1);
                        cnt_d   = '0;
                        state_d = StSqrt;
                    end else begin
                        out_d   = res;
                        carry_d = res_c;
                        zero_d  = (res == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            StSqrt: begin
                // Sum of the first n odd numbers is n^2, so the count of
                // successful subtractions is floor(sqrt(in_dr)).
                if ({1'b0, rem_q} >= odd_q) begin
                    rem_d = rem_q - odd_q[WIDTH-1:0];
                    odd_d = odd_q + (WIDTH+1)'(2);
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    out_d   = cnt_q;
                    carry_d = (rem_q != '0);
                    zero_d  = (cnt_q == '0);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            odd_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            odd_q   <= odd_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q == StSqrt);
    assign bus.done    = done_q;
    assign bus.out_reg = out_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [15:0] out;
        logic        c;
        logic        z;
        int          at;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    seq_alu_if #(.WIDTH(8))  bus8 ();
    seq_alu_if #(.WIDTH(16)) bus16 ();

    seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    seq_alu #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare whenever a DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (bus8.busy && bus8.done) begin
                failures++;
                $display("FAIL busy_done_8 busy=%b done=%b required not both", bus8.busy, bus8.done);
            end
            checks++;
            if (bus16.busy && bus16.done) begin
                failures++;
                $display("FAIL busy_done_16 busy=%b done=%b required not both", bus16.busy, bus16.done);
            end
            if (bus8.done) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL extra_done_8 at cycle %0d required no done", cyc);
                end else begin
                    e = q8.pop_front();
                    if (bus8.out_reg !== e.out[7:0] || bus8.carry !== e.c || bus8.zero !== e.z
                        || cyc != e.at) begin
                        failures++;
                        $display("FAIL result_8 got out=%h c=%b z=%b cyc=%0d required out=%h c=%b z=%b cyc=%0d",
                                 bus8.out_reg, bus8.carry, bus8.zero, cyc, e.out[7:0], e.c, e.z, e.at);
                    end
                end
            end
            if (bus16.done) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL extra_done_16 at cycle %0d required no done", cyc);
                end else begin
                    e = q16.pop_front();
                    if (bus16.out_reg !== e.out || bus16.carry !== e.c || bus16.zero !== e.z
                        || cyc != e.at) begin
                        failures++;
                        $display("FAIL result_16 got out=%h c=%b z=%b cyc=%0d required out=%h c=%b z=%b cyc=%0d",
                                 bus16.out_reg, bus16.carry, bus16.zero, cyc, e.out, e.c, e.z, e.at);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // lat: edges after the accepting edge until done is visible (0 for single-cycle ops).
    task automatic issue8(input logic [2:0] op, input logic [7:0] ac, input logic [7:0] dr,
                          input bit push, input logic [7:0] eo, input logic ec, input logic ez,
                          input int lat);
        exp_t e;
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.opcode = op;
        bus8.in_ac  = ac;
        bus8.in_dr  = dr;
        if (push) begin
            e.out = {8'h00, eo};
            e.c   = ec;
            e.z   = ez;
            e.at  = cyc + 1 + lat;
            q8.push_back(e);
        end
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] ac, input logic [15:0] dr,
                           input logic [15:0] eo, input logic ec, input logic ez, input int lat);
        exp_t e;
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.opcode = op;
        bus16.in_ac  = ac;
        bus16.in_dr  = dr;
        e.out = eo;
        e.c   = ec;
        e.z   = ez;
        e.at  = cyc + 1 + lat;
        q16.push_back(e);
        @(posedge clk);
        #1 bus16.start = 1'b0;
    endtask

    task automatic drain8(input int budget, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (bus8.busy) nbusy++;
            if (q8.size() == 0) break;
        end
        if (q8.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_8 pending=%0d required 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic drain16(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (q16.size() == 0) break;
        end
        if (q16.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_16 pending=%0d required 0", q16.size());
            q16.delete();
        end
    endtask

    initial begin
        int  nb;
        bit  seen;
        bus8.start  = 1'b0; bus8.opcode  = 3'b000; bus8.in_ac  = '0; bus8.in_dr  = '0;
        bus16.start = 1'b0; bus16.opcode = 3'b000; bus16.in_ac = '0; bus16.in_dr = '0;
        #1;
        chk("reset_out8", {8'h00, bus8.out_reg}, 16'h0000);
        chk("reset_flags8", {11'd0, bus8.busy, bus8.done, bus8.carry, bus8.zero, 1'b0}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops: op, ac, dr, push, out, carry, zero, latency
        issue8(3'b000, 8'd200, 8'd100, 1, 8'd44,  1'b1, 1'b0, 0);
        issue8(3'b001, 8'd5,   8'd7,   1, 8'hFE,  1'b1, 1'b0, 0);
        issue8(3'b010, 8'd4,   8'd4,   1, 8'h01,  1'b0, 1'b0, 0);
        issue8(3'b010, 8'd4,   8'd5,   1, 8'h00,  1'b0, 1'b1, 0);
        issue8(3'b011, 8'd0,   8'h84,  1, 8'h08,  1'b1, 1'b0, 0);
        issue8(3'b110, 8'd0,   8'hF0,  1, 8'h0F,  1'b0, 1'b0, 0);
        issue8(3'b101, 8'h00,  8'h33,  1, 8'h00,  1'b0, 1'b1, 0);
        issue8(3'b100, 8'h00,  8'h33,  1, 8'h33,  1'b0, 1'b0, 0);
        drain8(10, nb);

        // Square roots
        issue8(3'b111, 8'd0, 8'd49, 1, 8'd7, 1'b0, 1'b0, 8);
        drain8(40, nb);
        chk("busy_cycles_49", 16'(nb), 16'd8);
        issue8(3'b111, 8'd0, 8'd0, 1, 8'd0, 1'b0, 1'b1, 1);
        drain8(40, nb);
        issue8(3'b111, 8'd0, 8'd255, 1, 8'd15, 1'b1, 1'b0, 16);
        drain8(40, nb);

        // start while busy is ignored
        issue8(3'b111, 8'd0, 8'd200, 1, 8'd14, 1'b1, 1'b0, 15);
        repeat (2) @(negedge clk);
        issue8(3'b000, 8'd1, 8'd1, 0, 8'd0, 1'b0, 1'b0, 0);
        drain8(40, nb);
        chk("out_after_ignored", {8'h00, bus8.out_reg}, 16'd14);

        // Asynchronous reset mid-sqrt
        issue8(3'b111, 8'd0, 8'd225, 0, 8'd0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out8", {8'h00, bus8.out_reg}, 16'h0000);
        chk("rst_mid_flags8", {11'd0, bus8.busy, bus8.done, bus8.carry, bus8.zero, 1'b0}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        issue8(3'b100, 8'd0, 8'd9, 1, 8'd9, 1'b0, 1'b0, 0);
        drain8(10, nb);

        // WIDTH=16: full-range sqrt, then back-to-back op in the done cycle
        issue16(3'b111, 16'h0000, 16'hFFFF, 16'd255, 1'b1, 1'b0, 256);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (bus16.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_wait_16 got no done required done");
        end
        issue16(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 0);
        drain16(20);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired required completion");
        $fatal(1, "watchdog");
    end
endmodule
